fb_scanout: RTL
===============

Name: fb_scanout

Overview:
- Downstream consumer of the 320x240x8 SPRAM framebuffer. Owns the framebuffer's single address port.
- On each frame, reads all 76,800 pixels in raster order, starting at a programmable top row that wraps circularly so the waterfall scrolls without copying data.
- Streams pixels to the LCD driver over a valid/ready interface.
- Arbitrates write requests from the waterfall line writer onto the same RAM port.

Parameters:
- DATA_W, 8, pixel width in bits.
- ADDR_W, 17, framebuffer address width.
- H_RES, 320, pixels per row.
- V_RES, 240, rows per frame.
- RD_LAT, 2, cycles from ram_addr being presented to matching ram_rdata being valid.
- FIFO_D, 4, output FIFO depth (power of 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- top_row  in  8  first row displayed; latched on an accepted start.
- busy  out  1  high in SCAN and DRAIN.
- wr_req  in  1  write request, held until acknowledged.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_ack  out  1  combinational; write performed this cycle.
- ram_addr  out  ADDR_W  framebuffer address.
- ram_wdata  out  DATA_W  framebuffer write data.
- ram_wen  out  1  framebuffer write enable.
- ram_rdata  in  DATA_W  framebuffer read data, RD_LAT cycles after its address.
- pix_data  out  DATA_W  pixel value.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  sink accepts the pixel.
- pix_sof  out  1  qualifies the first pixel of the frame.
- pix_eol  out  1  qualifies the last pixel of each row.

Behaviour:
- Reset values: busy=0, pix_valid=0, pix_sof=0, pix_eol=0, ram_wen=0, ram_addr=0, ram_wdata=0, pix_data=0.
- Reset effects: FIFO emptied, in-flight read tags cleared, FSM to IDLE. Applies mid-frame too; RAM data returning after reset is discarded.
- FSM IDLE -> SCAN: start=1. Latches row_ptr = top_row, or 0 if top_row >= V_RES. Sets base = row_ptr*H_RES, computed once by shift-add (320 = 256 + 64). Clears col.
- FSM SCAN -> DRAIN: when the read for the 76,800th pixel is issued.
- FSM DRAIN -> IDLE: when no read is in flight, the FIFO is empty, and the last pixel has been accepted.
- start is ignored outside IDLE.
- Read address is base + col, with col = 0..H_RES-1.
- Row advance: when col wraps, base += H_RES. If the result is >= H_RES*V_RES (76,800), base wraps to 0.
- A row counter (0..V_RES-1) ends the frame independently of address wrap.
- Read issue condition: state=SCAN, port not used by a write this cycle, and inflight + fifo_count < FIFO_D. This condition guarantees the FIFO never overflows.
- Read tracking: a shift register of depth RD_LAT carries a valid bit plus sof/eol tags alongside each issued read. ram_rdata is pushed into the FIFO when the tag emerges.
- Arbitration: write has priority, except in the cycle after a granted write, when a pending read issue wins.
  - wr_ack = wr_req & ~(prev_write & read_wanted).
  - On wr_ack: ram_addr=wr_addr, ram_wdata=wr_data, ram_wen=1.
  - Otherwise ram_wen=0 and ram_addr carries the read address (held when no read is issued).
  - Writes are accepted in every state, including IDLE.
- Pixel output: the FIFO head drives pix_data, pix_sof and pix_eol. Pop occurs on pix_valid & pix_ready.
  - pix_valid stays high until accepted; data is stable while stalled.
  - FIFO push and pop in the same cycle are both honoured, count unchanged.
- Latency, ready=1, no writes: start accepted at edge T0, first read issued in cycle T0+1, pix_valid first high in cycle T0+1+RD_LAT+1. Steady state thereafter is 1 pixel per cycle.
- Reading a pixel in the same cycle it is written is not possible (single port). A write to a not-yet-read address is visible to the scan.

Test Plan:
- RAM model preloaded with mem[a] = a[7:0]; top_row=0; pix_ready=1 -> 76,800 pixels with pix_data = addr[7:0], first pix_valid 4 cycles after the start edge, pix_sof on beat 0 only, pix_eol on beats 319, 639, ..., busy drops once the last beat is accepted.
- top_row=239 -> first pixel from address 76,480, beat 320 from address 0, last beat from address 76,479; top_row=250 -> scan starts at address 0.
- pix_ready held low for 20 cycles mid-row, then toggled 1/0 -> no loss or duplication, ram_addr frozen once 4 are outstanding, pixel sequence unchanged.
- wr_req held high throughout a frame with incrementing writes -> wr_ack on alternating cycles, reads interleave, frame completes in about 2x76,800 cycles, RAM model contents match the writes.
- reset pulsed after beat 1000 -> pix_valid=0 and busy=0 next cycle, stale RAM returns are not emitted; new start with top_row=5 begins cleanly at address 1,600.
- start pulsed while busy -> ignored; frame length stays 76,800 with no restart.

Source files
------------

// File: rtl/fb_scanout_if.sv
// fb_scanout_if: the bus signals around the framebuffer scan-out engine.
//   - Write port from the line writer: wr_req / wr_addr / wr_data in, wr_ack out.
//   - Single-port framebuffer RAM: ram_addr / ram_wdata / ram_wen out,
//     ram_rdata in (returns a fixed number of cycles after its address).
//   - Pixel stream to the LCD driver: pix_data / pix_valid / pix_sof / pix_eol
//     out, pix_ready in.
// The master modport is the scan-out engine; the slave modport is everything
// around it (line writer, RAM and LCD driver).
interface fb_scanout_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 17
) ();

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_wen;
  logic [DATA_W-1:0] ram_rdata;

  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_sof;
  logic              pix_eol;

  modport master (
    input  wr_req, wr_addr, wr_data, ram_rdata, pix_ready,
    output wr_ack, ram_addr, ram_wdata, ram_wen,
    output pix_data, pix_valid, pix_sof, pix_eol
  );

  modport slave (
    output wr_req, wr_addr, wr_data, ram_rdata, pix_ready,
    input  wr_ack, ram_addr, ram_wdata, ram_wen,
    input  pix_data, pix_valid, pix_sof, pix_eol
  );

endinterface

// File: rtl/fb_scanout.sv
// fb_scanout: reads the H_RES x V_RES framebuffer in raster order, starting at
// a programmable top row that wraps circularly, and streams the pixels out
// over valid/ready. The same single RAM port also serves the line writer.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   start        one-cycle pulse, begins a frame (only honoured when idle)
//   top_row      first displayed row, latched on an accepted start
//   busy         high while a frame is being read or drained
//   bus          fb_scanout_if.master: write port, RAM port, pixel stream
module fb_scanout #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 17,
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int RD_LAT = 2,
  parameter int FIFO_D = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [7:0]   top_row,
  output logic         busy,
  fb_scanout_if.master bus
);

  localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int PTR_W = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = DATA_W + 2;

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(H_RES - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(V_RES - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(H_RES);
  localparam logic [ADDR_W-1:0] FRAME_PIX = ADDR_W'(H_RES * V_RES);
  localparam int unsigned       V_RES_U   = V_RES;
  localparam int unsigned       FIFO_D_U  = FIFO_D;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN
  } state_t;

  // Row start address as a sum of shifted copies of the row, one per set bit
  // of H_RES (for 320 that is row<<8 + row<<6), so no multiplier is built.
  function automatic logic [ADDR_W-1:0] row_base(input logic [7:0] row);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int b = 0; b < ADDR_W; b++) begin
      if (H_RES[b]) acc = acc + (ADDR_W'(row) << b);
    end
    return acc;
  endfunction

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  base_q;
  logic [ADDR_W-1:0]  last_rd_addr_q;
  logic [COL_W-1:0]   col_q;
  logic [ROW_W-1:0]   row_q;
  logic               prev_write_q;

  // Read tags travel alongside the RAM pipeline; stage RD_LAT-1 lines up
  // with ram_rdata.
  logic [RD_LAT-1:0]  tag_v_q;
  logic [RD_LAT-1:0]  tag_sof_q;
  logic [RD_LAT-1:0]  tag_eol_q;

  logic [ENT_W-1:0]   fifo_mem [FIFO_D];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  int unsigned        inflight;
  logic               read_wanted;
  logic               wr_ack;
  logic               rd_issue;
  logic [ADDR_W-1:0]  rd_addr;
  logic [ADDR_W-1:0]  base_step;
  logic [ADDR_W-1:0]  base_next;
  logic               col_last;
  logic               row_last;
  logic               start_accept;
  logic [7:0]         row_ptr;
  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic [ENT_W-1:0]   head;

  // NOTE: every always_comb output gets a default first, so no path through
  // the block can leave a variable unassigned and infer a latch.
  always_comb begin
    inflight = 0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + {31'b0, tag_v_q[i]};
    end
  end

  // Credit check: reads in flight plus buffered pixels never exceed the FIFO,
  // so a returning read always has a slot.
  assign read_wanted = (state_q == S_SCAN) &&
                       ((inflight + 32'(count_q)) < FIFO_D_U);
  // Writes win, except right after a granted write when a read is pending;
  // that keeps both sides moving when the writer never lets go.
  assign wr_ack      = bus.wr_req && !(prev_write_q && read_wanted);
  assign rd_issue    = read_wanted && !wr_ack;

  assign rd_addr     = base_q + ADDR_W'(col_q);
  assign col_last    = (col_q == COL_LAST);
  assign row_last    = (row_q == ROW_LAST);
  assign base_step   = base_q + ROW_STEP;
  assign base_next   = (base_step >= FRAME_PIX) ? '0 : base_step;

  assign start_accept = (state_q == S_IDLE) && start;
  assign row_ptr      = (32'(top_row) >= V_RES_U) ? 8'd0 : top_row;

  assign fifo_empty  = (count_q == '0);
  assign head        = fifo_mem[rd_ptr_q];
  assign push        = tag_v_q[RD_LAT-1];
  assign pop         = bus.pix_valid && bus.pix_ready;

  // RAM port: a granted write owns it; otherwise it shows the read address,
  // holding the last one while no read is issued.
  assign bus.wr_ack    = wr_ack;
  assign bus.ram_wen   = wr_ack;
  assign bus.ram_wdata = wr_ack ? bus.wr_data : '0;
  assign bus.ram_addr  = wr_ack   ? bus.wr_addr :
                         rd_issue ? rd_addr     : last_rd_addr_q;

  // Head fields are masked while empty so outputs read zero after reset even
  // though the storage itself is never cleared.
  assign bus.pix_valid = !fifo_empty;
  assign bus.pix_data  = fifo_empty ? '0 : head[DATA_W-1:0];
  assign bus.pix_sof   = !fifo_empty && head[DATA_W+1];
  assign bus.pix_eol   = !fifo_empty && head[DATA_W];

  assign busy = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_SCAN;
      S_SCAN:  if (rd_issue && col_last && row_last) state_d = S_DRAIN;
      S_DRAIN: if ((inflight == 0) && fifo_empty) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Address generation. The row counter, not the wrapping base, ends the
  // frame, so a frame starting mid-buffer still reads exactly V_RES rows.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q         <= '0;
      col_q          <= '0;
      row_q          <= '0;
      last_rd_addr_q <= '0;
      prev_write_q   <= 1'b0;
    end else begin
      prev_write_q <= wr_ack;
      if (start_accept) begin
        base_q <= row_base(row_ptr);
        col_q  <= '0;
        row_q  <= '0;
      end else if (rd_issue) begin
        last_rd_addr_q <= rd_addr;
        if (col_last) begin
          col_q  <= '0;
          base_q <= base_next;
          row_q  <= row_last ? '0 : row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
    end
  end

  // Clearing the valid tags on reset is what discards RAM data still in the
  // pipeline from an aborted frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_v_q   <= '0;
      tag_sof_q <= '0;
      tag_eol_q <= '0;
    end else begin
      tag_v_q[0]   <= rd_issue;
      tag_sof_q[0] <= rd_issue && (col_q == '0) && (row_q == '0);
      tag_eol_q[0] <= rd_issue && col_last;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v_q[i]   <= tag_v_q[i-1];
        tag_sof_q[i] <= tag_sof_q[i-1];
        tag_eol_q[i] <= tag_eol_q[i-1];
      end
    end
  end

  // NOTE: FIFO storage has no reset; the pointers and count define which
  // entries are meaningful, so clearing the array would only add logic.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {tag_sof_q[RD_LAT-1], tag_eol_q[RD_LAT-1], bus.ram_rdata};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
